// File: rtl/bank_request_dispatcher_pkg.sv
// types_def: shared request types and default sizing for the bank request dispatcher.
//   request_t : packed request {req_type, data, addr} as carried in every bank FIFO entry
//   data_width, address_width, banks_no, read_entries_log : default geometry
package types_def;

   localparam int unsigned data_width       = 32;
   localparam int unsigned address_width    = 26;
   localparam int unsigned banks_no         = 16;
   localparam int unsigned read_entries_log = 5;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_type_e;

   typedef struct packed {
      req_type_e                  req_type;
      logic [data_width-1:0]      data;
      logic [address_width-1:0]   addr;
   } request_t;

endpackage

// File: rtl/bank_request_dispatcher_fifo.sv
// bank_fifo: first-word-fall-through FIFO holding the requests queued for one bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry (ignored when full)
//   pop        : drop the head (ignored when empty)
//   dout       : head entry, valid while count != 0
//   full       : count == DEPTH
//   count      : occupancy, 0..DEPTH
module bank_fifo
   import types_def::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
         else if (!do_push && do_pop) count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bank_request_dispatcher.sv
// bank_request_dispatcher: accepts RNIC requests, decodes the target bank, allocates a
// read tag from a free pool and queues each request in a per-bank FIFO whose heads are
// presented to the bank schedulers.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake; in_type 1=write 0=read, in_data, in_addr
//   bank_valid_o          : per-bank head valid
//   bank_req_o/bank_tag_o : per-bank head {type,data,addr} and read tag (0 for writes)
//   bank_pop_i            : per-bank scheduler grant, pops the head
//   rel_valid_i/rel_tag_i : read completion, returns a tag to the pool
//   tags_free_o           : registered free-tag count
//   bank_count_o          : per-bank occupancy
//   err_o                 : sticky error (pop of empty bank, release of free tag)
// Build option: BANK_HASH_EN XOR-folds the top address bits into the bank index.
module bank_request_dispatcher
   import types_def::*;
#(
   parameter int unsigned NUM_BANKS = banks_no,
   parameter int unsigned DATA_W    = data_width,
   parameter int unsigned ADDR_W    = address_width,
   parameter int unsigned BANK_POS  = 3,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned NUM_TAGS  = 1 << read_entries_log,
   localparam int unsigned BANK_W   = $clog2(NUM_BANKS),
   localparam int unsigned TAG_W    = $clog2(NUM_TAGS),
   localparam int unsigned REQ_W    = 1 + DATA_W + ADDR_W,
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_type,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [ADDR_W-1:0]          in_addr,
   output logic [NUM_BANKS-1:0]       bank_valid_o,
   output logic [NUM_BANKS*REQ_W-1:0] bank_req_o,
   output logic [NUM_BANKS*TAG_W-1:0] bank_tag_o,
   input  logic [NUM_BANKS-1:0]       bank_pop_i,
   input  logic                       rel_valid_i,
   input  logic [TAG_W-1:0]           rel_tag_i,
   output logic [TAG_W:0]             tags_free_o,
   output logic [NUM_BANKS*CNT_W-1:0] bank_count_o,
   output logic                       err_o
);

   localparam int unsigned ENT_W = TAG_W + REQ_W;

   logic [BANK_W-1:0]    bank;
   logic [NUM_BANKS-1:0] full;
   logic [NUM_BANKS-1:0] push;
   logic [NUM_TAGS-1:0]  free_q;
   logic [NUM_TAGS-1:0]  free_d;
   logic [TAG_W:0]       free_cnt_d;
   logic [TAG_W-1:0]     alloc_tag;
   logic [TAG_W-1:0]     tag_in;
   logic                 accept;
   logic                 alloc;
   logic                 rel_bad;
   logic                 pop_bad;

`ifdef BANK_HASH_EN
   assign bank = in_addr[BANK_POS +: BANK_W] ^ in_addr[ADDR_W-1 -: BANK_W];
`else
   assign bank = in_addr[BANK_POS +: BANK_W];
`endif

   // Ready depends only on inputs and registered state; pops and releases
   // landing this cycle are not credited until the next one.
   assign in_ready = rst_n & ~full[bank] & (in_type | (tags_free_o != '0));
   assign accept   = in_valid & in_ready;
   assign alloc    = accept & (in_type == REQ_READ);
   assign tag_in   = alloc ? alloc_tag : '0;
   assign pop_bad  = |(bank_pop_i & ~bank_valid_o);

   // Lowest free tag, chosen from the pre-release bitmap.
   always_comb begin
      alloc_tag = '0;
      for (int unsigned i = NUM_TAGS; i > 0; i--) begin
         if (free_q[i-1]) alloc_tag = TAG_W'(i-1);
      end
   end

   always_comb begin
      free_d  = free_q;
      rel_bad = rel_valid_i & free_q[rel_tag_i];
      if (alloc) free_d[alloc_tag] = 1'b0;
      if (rel_valid_i && !free_q[rel_tag_i]) free_d[rel_tag_i] = 1'b1;
      free_cnt_d = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         free_cnt_d = free_cnt_d + (TAG_W+1)'(free_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_q      <= '1;
         tags_free_o <= (TAG_W+1)'(NUM_TAGS);
         err_o       <= 1'b0;
      end else begin
         free_q      <= free_d;
         tags_free_o <= free_cnt_d;
         if (rel_bad || pop_bad) err_o <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [ENT_W-1:0] ent;

      assign push[g] = accept && (bank == BANK_W'(g));

      bank_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[g]),
         .din   ({tag_in, in_type, in_data, in_addr}),
         .pop   (bank_pop_i[g]),
         .dout  (ent),
         .valid (bank_valid_o[g]),
         .full  (full[g]),
         .count (bank_count_o[g*CNT_W +: CNT_W])
      );

      assign bank_tag_o[g*TAG_W +: TAG_W] = ent[ENT_W-1 -: TAG_W];
      assign bank_req_o[g*REQ_W +: REQ_W] = ent[REQ_W-1:0];
   end

endmodule

// File: tb/tb_bank_request_dispatcher.sv
// Scoreboard bench for bank_request_dispatcher: the stimulus process predicts acceptance,
// tag allocation and per-bank ordering with queues; the monitor process compares popped
// heads against the queued expectations.
module tb_bank_request_dispatcher;

   localparam int NB = 16;
   localparam int RW = 59;
   localparam int TW = 5;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_type = 1'b0;
   logic [31:0]       in_data = '0;
   logic [25:0]       in_addr = '0;
   logic [NB-1:0]     bank_valid_o;
   logic [NB*RW-1:0]  bank_req_o;
   logic [NB*TW-1:0]  bank_tag_o;
   logic [NB-1:0]     bank_pop_i = '0;
   logic              rel_valid_i = 1'b0;
   logic [TW-1:0]     rel_tag_i = '0;
   logic [TW:0]       tags_free_o;
   logic [NB*CW-1:0]  bank_count_o;
   logic              err_o;

   bank_request_dispatcher dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_type      (in_type),
      .in_data      (in_data),
      .in_addr      (in_addr),
      .bank_valid_o (bank_valid_o),
      .bank_req_o   (bank_req_o),
      .bank_tag_o   (bank_tag_o),
      .bank_pop_i   (bank_pop_i),
      .rel_valid_i  (rel_valid_i),
      .rel_tag_i    (rel_tag_i),
      .tags_free_o  (tags_free_o),
      .bank_count_o (bank_count_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] req;
      int            tag;
   } ent_t;

   ent_t          q [NB][$];
   bit            ref_free [32];
   bit            ref_err;
   logic [NB-1:0] pop_ok = '0;
   int            total = 0;
   int            bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bank_of(input logic [25:0] a);
      int r;
      r = int'((a >> 3) & 26'hF);
`ifdef BANK_HASH_EN
      r = r ^ int'((a >> 22) & 26'hF);
`endif
      return r;
   endfunction

   function automatic int nfree();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(ref_free[i]);
      return n;
   endfunction

   function automatic logic [NB-1:0] busy_banks();
      logic [NB-1:0] m = '0;
      for (int k = 0; k < NB; k++) m[k] = (q[k].size() != 0);
      return m;
   endfunction

   function automatic int lowest_busy();
      for (int i = 0; i < 32; i++) if (!ref_free[i]) return i;
      return -1;
   endfunction

   // One cycle: drive at posedge+1, check and update the model at negedge.
   task automatic step(input bit v, input bit t, input logic [31:0] d, input logic [25:0] a,
                       input logic [NB-1:0] pop, input bit rv, input int rt);
      int  b;
      int  tg;
      bit  exp_rdy;
      bit  rel_bad;
      in_valid    = v;
      in_type     = t;
      in_data     = d;
      in_addr     = a;
      bank_pop_i  = pop;
      rel_valid_i = rv;
      rel_tag_i   = TW'(rt);
      @(negedge clk);
      b       = bank_of(a);
      exp_rdy = (q[b].size() < 8) && (t || nfree() > 0);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("tags_free", 64'(tags_free_o), 64'(nfree()));
      chk("err", 64'(err_o), 64'(ref_err));
      chk("count", 64'(bank_count_o[b*CW +: CW]), 64'(q[b].size()));
      for (int k = 0; k < NB; k++) begin
         if (pop[k]) begin
            if (q[k].size() == 0) ref_err = 1'b1;
            else pop_ok[k] = 1'b1;
         end
      end
      rel_bad = rv && ref_free[rt];
      if (v && exp_rdy) begin
         tg = 0;
         if (!t) begin
            for (int i = 0; i < 32; i++) if (ref_free[i]) begin tg = i; break; end
            ref_free[tg] = 1'b0;
         end
         q[b].push_back('{req: {t, d, a}, tag: tg});
      end
      if (rv) begin
         if (rel_bad) ref_err = 1'b1;
         else ref_free[rt] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_type  = 1'b1;
      in_addr  = 26'h8;
      #1;
      chk("rst_valid", 64'(bank_valid_o), 64'h0);
      chk("rst_tags_free", 64'(tags_free_o), 64'd32);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      chk("rst_counts", bank_count_o, 64'h0);
      for (int k = 0; k < NB; k++) q[k].delete();
      for (int i = 0; i < 32; i++) ref_free[i] = 1'b1;
      ref_err  = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int n = 0; n < 40; n++) begin
         step(0, 1, 0, 0, busy_banks(), lowest_busy() >= 0, lowest_busy() < 0 ? 0 : lowest_busy());
      end
   endtask

   // Monitor: compare each popped head with the oldest expectation of that bank.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < NB; k++) begin
            if (pop_ok[k]) begin
               e = q[k].pop_front();
               chk("head_valid", 64'(bank_valid_o[k]), 64'h1);
               chk("head_req", 64'(bank_req_o[k*RW +: RW]), 64'(e.req));
               chk("head_tag", 64'(bank_tag_o[k*TW +: TW]), 64'(e.tag));
            end
         end
         pop_ok = '0;
      end
   end

   initial begin
      logic [NB-1:0] pm;
      int            rt;
      @(posedge clk);
      #1;
      do_reset();

      // first write to bank 1, then pop it
      step(1, 1, 32'hCAFE0001, 26'h8, '0, 0, 0);
      step(0, 1, 0, 26'h8, 16'h0002, 0, 0);

      // fill bank 2, full back-pressure, same-cycle pop does not help
      for (int i = 0; i < 8; i++) step(1, 1, $urandom, 26'h10, '0, 0, 0);
      step(1, 1, 32'h99, 26'h10, '0, 0, 0);
      step(1, 1, 32'h9A, 26'h10, 16'h0004, 0, 0);
      step(1, 1, 32'h9B, 26'h10, '0, 0, 0);
      drain();

      // exhaust tags across banks 4..7, writes still accepted, reuse of released tag
      for (int i = 0; i < 32; i++) step(1, 0, 0, 26'((4 + i / 8) << 3), '0, 0, 0);
      step(1, 0, 0, 26'h40, '0, 0, 0);
      step(1, 1, 32'h1234, 26'h40, '0, 0, 0);
      step(0, 0, 0, 26'h40, '0, 1, 5);
      step(1, 0, 0, 26'h48, '0, 0, 0);
      drain();

      // randomized legal traffic
      for (int n = 0; n < 2000; n++) begin
         pm = '0;
         for (int k = 0; k < NB; k++) if (q[k].size() != 0 && $urandom_range(3) == 0) pm[k] = 1'b1;
         rt = int'($urandom_range(31));
         step($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom,
              {4'($urandom), 16'($urandom), 2'($urandom), 3'($urandom)},
              pm, !ref_free[rt] && $urandom_range(2) == 0, rt);
      end
      drain();

      // protocol errors: release of free tag, pop of empty bank; sticky
      step(0, 1, 0, 26'h18, '0, 1, 7);
      step(0, 1, 0, 26'h18, 16'h0008, 0, 0);
      step(1, 1, 32'h77, 26'h18, '0, 0, 0);
      step(0, 1, 0, 26'h18, '0, 0, 0);
      step(0, 1, 0, 26'h18, 16'h0008, 0, 0);

      // reset with requests queued and tags busy
      step(1, 0, 0, 26'h00, '0, 0, 0);
      step(1, 0, 0, 26'h08, '0, 0, 0);
      step(1, 0, 0, 26'h10, '0, 0, 0);
      step(1, 1, 32'h55, 26'h18, '0, 0, 0);
      step(0, 1, 0, 26'h18, '0, 0, 0);
      do_reset();
      step(1, 0, 32'h0, 26'h20, '0, 0, 0);
      step(0, 0, 0, 26'h20, 16'h0010, 0, 0);
      step(0, 0, 0, 26'h20, '0, 1, 0);
      step(0, 0, 0, 26'h20, '0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
